// File: rtl/k2_pkg.sv
// Shared constants, FSM encoding and the modular reduction ladder used by the
// k2unred inverse-K2 multiplier (q = 3329, k = 13).
package k2_pkg;

    localparam int Q     = 3329;
    localparam int K     = 13;
    localparam int K2INV = 2285;
    localparam int W     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtract the single largest m*Q (1 <= m <= n) that does not exceed t.
    function automatic logic [15:0] modsub_ladder(input logic [15:0] t, input int n);
        logic [15:0] res;
        logic        hit;
        res = t;
        hit = 1'b0;
        for (int m = 6; m >= 1; m--) begin
            if (!hit && (m <= n) && (t >= 16'(m * Q))) begin
                res = t - 16'(m * Q);
                hit = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/k2unred_step.sv
// One combinational iteration of the MSB-first shift-add modular multiplier:
// acc_nxt = (2^STEP * acc + bits * K2INV) mod Q, for canonical acc.
module k2unred_step
    import k2_pkg::*;
#(
    parameter int STEP   = 1,
    parameter int LADDER = 2
) (
    input  logic [W-1:0]    acc,
    input  logic [STEP-1:0] bits,
    output logic [W-1:0]    acc_nxt
);

    logic [15:0] t;

    // acc < Q keeps t below (2^STEP + 2^STEP - 1) * Q, so one ladder pass is canonical.
    always_comb begin
        t       = (16'(acc) << STEP) + 16'(bits) * 16'(K2INV);
        acc_nxt = W'(modsub_ladder(t, LADDER));
    end

endmodule

// File: rtl/k2unred.sv
// Maps a K2-domain value back to the normal domain: r = x * 2285 mod 3329.
// Define K2UNRED_FAST_EN to consume two multiplier bits per cycle instead of one.
module k2unred
    import k2_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] x,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] r,
    output logic         busy
);

`ifdef K2UNRED_FAST_EN
    localparam int STEP   = 2;
    localparam int LADDER = 6;
`else
    localparam int STEP   = 1;
    localparam int LADDER = 2;
`endif
    localparam logic [3:0] CNT_INIT = 4'(W / STEP - 1);

    state_t         state, state_nxt;
    logic [W-1:0]   xs;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic [3:0]     cnt;

    k2unred_step #(
        .STEP   (STEP),
        .LADDER (LADDER)
    ) u_step (
        .acc     (acc),
        .bits    (xs[W-1 -: STEP]),
        .acc_nxt (acc_nxt)
    );

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_rdy only in IDLE, out_vld only in DONE, so they never overlap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_vld)     state_nxt = CALC;
            CALC:    if (cnt == '0)  state_nxt = DONE;
            DONE:    if (out_rdy)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        xs  <= x;
                        acc <= '0;
                        cnt <= CNT_INIT;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    xs  <= {xs[W-1-STEP:0], {STEP{1'b0}}};
                    if (cnt != '0) cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_rdy  = (state == IDLE) && !rst;
    assign out_vld = (state == DONE);
    assign r       = (state == DONE) ? acc : '0;
    assign busy    = (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_k2unred.sv
// Self-checking bench for k2unred: scoreboard queue filled by the driver,
// drained by an independent monitor, reference from plain modular arithmetic.
module tb_k2unred;

    localparam int Q     = 3329;
    localparam int K2INV = 2285;
    localparam int W     = 12;
`ifdef K2UNRED_FAST_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif
    localparam int PERIOD = LAT + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] x = '0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [W-1:0] r;
    logic         busy;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic         prev_vld = 1'b0;
    logic         chk_space = 1'b0;
    logic         have_prev = 1'b0;
    int           last_rise = 0;

    k2unred dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .x       (x),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .r       (r),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_unred(input longint v);
        return int'((v * K2INV) % Q);
    endfunction

    function automatic int ref_k2red(input longint v);
        return int'((v * 169) % Q);
    endfunction

    // Monitor: latency at each rising out_vld, value on each output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld && !prev_vld) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_out_vld", 1, 0);
                end else begin
                    check("latency", cyc - acc_q.pop_front() + 1, LAT);
                end
                if (chk_space && have_prev) check("b2b_spacing", cyc - last_rise, PERIOD);
                have_prev = 1'b1;
                last_rise = cyc;
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("r_value", r, exp_q.pop_front());
                    check("r_canonical", (r < Q) ? 1 : 0, 1);
                end
            end
        end
        prev_vld = out_vld;
    end

    // Present v, wait for acceptance, push expected result at the accept.
    task automatic send(input logic [W-1:0] v, input int e, input logic keep_vld);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        x = v;
        in_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                exp_q.push_back(W'(e));
                acc_q.push_back(cyc + 1);
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep_vld) in_vld = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_vld) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [W-1:0] b2b_x[8];
        longint       rt_x[4];
        int           bp_exp;
        bit           ok;

        // Reset state
        #2;
        check("rst_in_rdy", in_rdy, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_rdy", in_rdy, 1);
        check("idle_busy", busy, 0);

        // Directed single ops
        send(12'd1,    2285, 1'b0); drain();
        send(12'd169,  1,    1'b0); drain();
        send(12'd338,  2,    1'b0); drain();
        send(12'd0,    0,    1'b0); drain();
        send(12'd3329, 0,    1'b0); drain();
        send(12'd4095, 2585, 1'b0); drain();

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] v;
            v = W'($urandom_range(0, 4095));
            send(v, ref_unred(v), 1'b0);
        end
        drain();

        // Round trip through a k2red model
        rt_x[0] = 3330; rt_x[1] = 65536; rt_x[2] = 99999; rt_x[3] = 600000;
        for (int i = 0; i < 4; i++) begin
            send(W'(ref_k2red(rt_x[i])), int'(rt_x[i] % Q), 1'b0);
        end
        drain();

        // Backpressure
        out_rdy = 1'b0;
        bp_exp = ref_unred(1234);
        send(12'd1234, bp_exp, 1'b0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_vld) begin ok = 1; break; end
        end
        check("bp_out_vld_seen", ok, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_vld = i[0];
            x = W'($urandom_range(0, 4095));
            @(negedge clk);
            check("bp_r_stable", r, bp_exp);
            check("bp_in_rdy_low", in_rdy, 0);
            check("bp_out_vld_held", out_vld, 1);
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_rdy", in_rdy, 1);
        repeat (20) @(negedge clk);
        check("bp_no_stray_sample", exp_q.size() + (out_vld ? 1 : 0), 0);

        // Back-to-back with in_vld held high
        for (int i = 0; i < 8; i++) b2b_x[i] = W'($urandom_range(0, 4095));
        chk_space = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 8; i++) send(b2b_x[i], ref_unred(b2b_x[i]), 1'b1);
        #1 in_vld = 1'b0;
        drain();
        chk_space = 1'b0;

        // Reset mid-CALC
        send(12'd2000, ref_unred(2000), 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_vld", out_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_in_rdy", in_rdy, 0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        send(12'd169, 1, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        check("post_abort_idle", out_vld, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
